// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: accepts one operation, holds it on the ALU for its latency, returns the result.
// Define ALU_SEQ_DIV_EN to accept DIV (10000) as a legal opcode with DIV_CYCLES of latency.
module alu_sequencer #(
  parameter int MUL_CYCLES = 16,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nx;
  logic        armed;
  logic [5:0]  cnt;
  logic [4:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        accept, legal, div_en, in_exec;
  logic [5:0]  lat;

`ifdef ALU_SEQ_DIV_EN
  assign div_en = 1'b1;
`else
  assign div_en = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin : decode
    // NOTE: defaults first so every path assigns lat/legal and no latch is inferred.
    legal = 1'b1;
    lat   = 6'd1;
    case (req_op)
      OP_OR, OP_AND, OP_NOT, OP_ADD, OP_SUB, OP_NEG: lat = 6'd1;
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        lat = (req_b[4:0] == 5'd0) ? 6'd1 : {1'b0, req_b[4:0]};
      OP_MUL: lat = 6'(MUL_CYCLES);
      OP_DIV: begin
        if (div_en) lat = 6'(DIV_CYCLES);
        else        legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin : next_state
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = legal ? EXEC : DONE;
      EXEC:    if (cnt == 6'd1) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // armed keeps req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cnt      <= 6'd0;
      op_q     <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state <= state_nx;
      armed <= 1'b1;
      if (accept) begin
        op_q     <= req_op;
        a_q      <= req_a;
        b_q      <= req_b;
        cnt      <= legal ? lat : 6'd0;
        rsp_data <= 32'd0;
        rsp_err  <= !legal;
      end else if (state == EXEC) begin
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) rsp_data <= alu_c;
      end
    end
  end

  assign in_exec   = (state == EXEC);
  assign req_ready = armed && (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign alu_op    = in_exec ? {op_q, 27'd0} : 32'd0;
  assign alu_a     = in_exec ? a_q : 32'd0;
  assign alu_b     = in_exec ? b_q : 32'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: timeline model of each transaction plus directed operations.
// Define ALU_SEQ_DIV_EN for both bench and RTL to exercise the DIV-enabled build.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_op, alu_a, alu_b, alu_c;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      5'b01011: return a | b;
      5'b01010: return a & b;
      5'b10010: return ~a;
      5'b00011: return a + b;
      5'b00100: return a - b;
      5'b10001: return 32'd0 - a;
      5'b00101: return a >> sh;
      5'b00110: return $signed(a) >>> sh;
      5'b00111: return a << sh;
      5'b01000: begin t = {a, a} >> sh; return t[31:0]; end
      5'b01001: begin t = {a, a} << sh; return t[63:32]; end
      5'b01111: return a * b;
      5'b10000: return (b == 32'd0) ? 32'd0 : a / b;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_c = alu_f(alu_op[31:27], alu_a, alu_b);

  function automatic bit f_legal(input logic [4:0] op);
    case (op)
      5'b01011, 5'b01010, 5'b10010, 5'b00011, 5'b00100, 5'b10001,
      5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01111: return 1'b1;
`ifdef ALU_SEQ_DIV_EN
      5'b10000: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic int f_lat(input logic [4:0] op, input logic [31:0] b);
    case (op)
      5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001: return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
      5'b01111: return 16;
      5'b10000: return 32;
      default:  return 1;
    endcase
  endfunction

  // Model: one optional transaction, described by its accept cycle, latency and result.
  int          cyc = 0;
  bit          m_started = 1'b0;
  bit          m_active = 1'b0;
  bit          m_legal = 1'b0;
  int          m_acc = 0;
  int          m_lat = 0;
  logic [4:0]  m_op = 5'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
  logic        e_exec, e_done;

  assign e_exec = m_active && m_legal && ((cyc - m_acc) < m_lat);
  assign e_done = m_active && !e_exec;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_started <= 1'b0;
      m_active  <= 1'b0;
      cyc       <= 0;
    end else begin
      cyc       <= cyc + 1;
      m_started <= 1'b1;
      if (m_active) begin
        if (e_done && rsp_ready) m_active <= 1'b0;
      end else if (m_started && req_valid) begin
        m_active <= 1'b1;
        m_acc    <= cyc + 1;
        m_op     <= req_op;
        m_a      <= req_a;
        m_b      <= req_b;
        m_legal  <= f_legal(req_op);
        m_lat    <= f_lat(req_op, req_b);
        m_res    <= f_legal(req_op) ? alu_f(req_op, req_a, req_b) : 32'd0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("m_req_ready", 32'(req_ready), 32'(m_started && !m_active));
      check("m_busy",      32'(busy),      32'(m_active));
      check("m_rsp_valid", 32'(rsp_valid), 32'(e_done));
      check("m_alu_op",    alu_op, e_exec ? {m_op, 27'd0} : 32'd0);
      check("m_alu_a",     alu_a,  e_exec ? m_a : 32'd0);
      check("m_alu_b",     alu_b,  e_exec ? m_b : 32'd0);
      if (e_done) begin
        check("m_rsp_data", rsp_data, m_res);
        check("m_rsp_err",  32'(rsp_err), 32'(!m_legal));
      end
    end
  end

  task automatic wait_accept(output bit ok);
    bit r;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      r = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issue one operation from a negedge; ends on the negedge after the response handshake.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] data, input bit err, input int hold, input bit keep);
    bit ok;
    int acc, got, n_exec;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    wait_accept(ok);
    if (!ok) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (!keep) req_valid = 1'b0;
    got = -1;
    n_exec = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        got = cyc - acc;
        break;
      end
      if (alu_op == {op, 27'd0}) n_exec++;
      if (keep) begin
        req_op = 5'($urandom);
        req_a  = $urandom;
        req_b  = $urandom;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({name, "_latency"}, 32'(got), 32'(lat));
    check({name, "_exec_cycles"}, 32'(n_exec), err ? 32'd0 : 32'(lat));
    check({name, "_data"}, rsp_data, data);
    check({name, "_err"}, 32'(rsp_err), 32'(err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_hold_data"}, rsp_data, data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit ok;
    reset = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_alu_op",    alu_op,         32'd0);
    #10 reset = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready), 32'd1);

    do_op("add",      5'b00011, 32'd5,          32'd7,          1,  32'd12,         1'b0, 0, 1'b0);
    do_op("sub",      5'b00100, 32'd50,         32'd8,          1,  32'd42,         1'b0, 0, 1'b0);
    do_op("or",       5'b01011, 32'hF0F0_0000,  32'h0000_0F0F,  1,  32'hF0F0_0F0F,  1'b0, 0, 1'b0);
    do_op("and",      5'b01010, 32'hFF00_FF00,  32'h0FF0_0FF0,  1,  32'h0F00_0F00,  1'b0, 0, 1'b0);
    do_op("not",      5'b10010, 32'h0000_FFFF,  32'd0,          1,  32'hFFFF_0000,  1'b0, 0, 1'b0);
    do_op("neg",      5'b10001, 32'd1,          32'd0,          1,  32'hFFFF_FFFF,  1'b0, 0, 1'b0);
    do_op("shl3",     5'b00111, 32'd1,          32'd3,          3,  32'd8,          1'b0, 0, 1'b0);
    do_op("shl0",     5'b00111, 32'h0000_ABCD,  32'd0,          1,  32'h0000_ABCD,  1'b0, 0, 1'b0);
    do_op("shl31",    5'b00111, 32'd1,          32'd31,         31, 32'h8000_0000,  1'b0, 0, 1'b0);
    do_op("shr",      5'b00101, 32'h8000_0000,  32'd4,          4,  32'h0800_0000,  1'b0, 0, 1'b0);
    do_op("shra",     5'b00110, 32'h8000_0000,  32'd4,          4,  32'hF800_0000,  1'b0, 0, 1'b0);
    do_op("ror",      5'b01000, 32'd1,          32'd1,          1,  32'h8000_0000,  1'b0, 0, 1'b0);
    do_op("ill_1f",   5'b11111, 32'd9,          32'd9,          0,  32'd0,          1'b1, 0, 1'b0);
    do_op("ill_0c",   5'b01100, 32'd3,          32'd3,          0,  32'd0,          1'b1, 0, 1'b0);
    do_op("mul_hold", 5'b01111, 32'd1234,       32'd5678,       16, 32'd7006652,    1'b0, 5, 1'b0);
    do_op("rol_keep", 5'b01001, 32'h8000_0001,  32'd4,          4,  32'h0000_0018,  1'b0, 0, 1'b1);
`ifdef ALU_SEQ_DIV_EN
    do_op("div_en",   5'b10000, 32'd100,        32'd7,          32, 32'd14,         1'b0, 0, 1'b0);
`else
    do_op("div_dis",  5'b10000, 32'd100,        32'd7,          0,  32'd0,          1'b1, 0, 1'b0);
`endif

    // Reset in the fourth EXEC cycle of a MUL.
    req_op = 5'b01111; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    wait_accept(ok);
    check("mulrst_accept", 32'(ok), 32'd1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mulrst_in_exec", alu_op, 32'h7800_0000);
    #2 reset = 1'b0;
    #1;
    check("arst_alu_op",    alu_op,         32'd0);
    check("arst_alu_a",     alu_a,          32'd0);
    check("arst_alu_b",     alu_b,          32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data",  rsp_data,       32'd0);
    check("arst_rsp_err",   32'(rsp_err),   32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(rsp_valid), 32'd0);
    end
    do_op("add_again", 5'b00011, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
